// File: rtl/text_console_writer.sv
// text_console_writer
//
// Streams bytes into a character/attribute text buffer held in byte-wide
// video RAM. Each cell is two bytes: character at BASE+2*pos, attribute at
// BASE+2*pos+1. Printable bytes are written with the attribute sampled at
// acceptance. CR, LF, BS and FF move the cursor or clear the screen. When the
// cursor runs off the bottom row, the screen scrolls up by one row. The scroll
// copies the bytes with a read/write pair per byte, then blanks the last row.
//
// Ports
//   clock, reset  : single clock, synchronous active-high reset
//   in_data       : byte to print or control code (08h BS, 0Ah LF, 0Ch FF, 0Dh CR)
//   in_valid      : in_data valid
//   in_ready      : byte accepted this cycle when in_valid & in_ready
//   attr          : attribute byte, latched when a byte is accepted
//   mem_address   : video RAM byte address
//   mem_wdata     : video RAM write data
//   mem_we        : video RAM write strobe, one byte per cycle
//   mem_rdata     : video RAM read data, one cycle after the read address
//   cursor        : (pos - 1) mod 2048, places the display underline on cell pos
//   busy          : high whenever the writer is not idle
module text_console_writer #(
  parameter logic [16:0] BASE = 17'hF000,
  parameter int          COLS = 80,
  parameter int          ROWS = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic [16:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [10:0] cursor,
  output logic        busy
);

  localparam logic [10:0] NCELLS       = 11'(COLS * ROWS);
  localparam logic [10:0] NCOLS        = 11'(COLS);
  localparam logic [10:0] LAST_ROW     = 11'(COLS * (ROWS - 1));
  localparam logic [16:0] ROW_BYTES    = 17'(2 * COLS);
  localparam logic [16:0] COPY_BYTES   = 17'(2 * COLS * (ROWS - 1));
  localparam logic [16:0] SCREEN_BYTES = 17'(2 * COLS * ROWS);

  typedef enum logic [2:0] {
    IDLE,
    WR_CHAR,
    WR_ATTR,
    SCR_RD,
    SCR_WR,
    FILL_CHAR,
    FILL_ATTR
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] pos_q, pos_d;
  logic [10:0] cursor_q, cursor_d;
  logic        home_q, home_d;   // full-screen clear: cursor goes home when the fill ends
  logic [16:0] off_q, off_d;     // byte offset from BASE for scroll copy and fills
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;

  logic        accept;
  logic [10:0] col;
  logic [16:0] cell_addr;

  // in_ready depends only on state and reset, never on in_valid.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign cursor    = cursor_q;
  assign col       = pos_q % NCOLS;
  assign cell_addr = BASE + {5'd0, pos_q, 1'b0};

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    home_d      = home_q;
    off_d       = off_q;
    char_d      = char_q;
    attr_d      = attr_q;
    mem_we      = 1'b0;
    mem_address = cell_addr;
    mem_wdata   = 8'h00;

    case (state_q)
      IDLE: begin
        if (accept) begin
          char_d = in_data;
          attr_d = attr;
          home_d = 1'b0;
          case (in_data)
            8'h0D: pos_d = pos_q - col;
            8'h0A: begin
              if (pos_q < LAST_ROW) begin
                pos_d = pos_q + NCOLS;
              end else begin
                // Bottom row: column and row stay put, the screen moves instead.
                off_d   = 17'd0;
                state_d = SCR_RD;
              end
            end
            8'h08: begin
              if (pos_q != 11'd0) pos_d = pos_q - 11'd1;
            end
            8'h0C: begin
              off_d   = 17'd0;
              home_d  = 1'b1;
              state_d = FILL_CHAR;
            end
            default: state_d = WR_CHAR;
          endcase
        end
      end

      WR_CHAR: begin
        mem_we    = 1'b1;
        mem_wdata = char_q;
        state_d   = WR_ATTR;
      end

      WR_ATTR: begin
        mem_we      = 1'b1;
        mem_address = cell_addr + 17'd1;
        mem_wdata   = attr_q;
        if (pos_q + 11'd1 == NCELLS) begin
          pos_d   = LAST_ROW;
          off_d   = 17'd0;
          state_d = SCR_RD;
        end else begin
          pos_d   = pos_q + 11'd1;
          state_d = IDLE;
        end
      end

      SCR_RD: begin
        mem_address = BASE + ROW_BYTES + off_q;
        state_d     = SCR_WR;
      end

      SCR_WR: begin
        mem_we      = 1'b1;
        mem_address = BASE + off_q;
        mem_wdata   = mem_rdata;
        off_d       = off_q + 17'd1;
        // Copy length equals the start offset of the last row, so the fill
        // continues straight on from the final copied byte.
        state_d     = (off_q + 17'd1 == COPY_BYTES) ? FILL_CHAR : SCR_RD;
      end

      FILL_CHAR: begin
        mem_we      = 1'b1;
        mem_address = BASE + off_q;
        mem_wdata   = 8'h20;
        off_d       = off_q + 17'd1;
        state_d     = FILL_ATTR;
      end

      FILL_ATTR: begin
        mem_we      = 1'b1;
        mem_address = BASE + off_q;
        mem_wdata   = attr_q;
        off_d       = off_q + 17'd1;
        if (off_q + 17'd1 == SCREEN_BYTES) begin
          state_d = IDLE;
          if (home_q) pos_d = 11'd0;
        end else begin
          state_d = FILL_CHAR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Cursor shadows the next pos, so it changes on the same edge as pos.
  assign cursor_d = pos_d - 11'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pos_q    <= 11'd0;
      cursor_q <= 11'h7FF;
      home_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      cursor_q <= cursor_d;
      home_q   <= home_d;
    end
  end

  always_ff @(posedge clock) begin
    off_q  <= off_d;
    char_q <= char_d;
    attr_q <= attr_d;
  end

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  attr = 8'h00;
  logic [16:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [10:0] cursor;
  logic        busy;

  text_console_writer dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .attr(attr), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cursor(cursor), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;

  // Video RAM model: untouched bytes read back a fixed address pattern.
  logic [7:0] mem [0:131071];
  bit         written [0:131071];

  function automatic logic [7:0] rd(input logic [16:0] a);
    return written[a] ? mem[a] : (a[7:0] ^ {7'd0, a[16]} ^ a[15:8] ^ 8'h5A);
  endfunction

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_address]     <= mem_wdata;
      written[mem_address] <= 1'b1;
    end
    mem_rdata <= rd(mem_address);
  end

  task automatic send(input logic [7:0] b, input logic [7:0] a);
    in_data  = b;
    attr     = a;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (cursor !== 11'd2047) $display("FAIL reset_cursor: got %0d expected 2047", cursor); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_print();
    wr_t e;
    int  cyc;
    apply_reset();
    exp_q.push_back('{17'hF000, 8'h41});
    exp_q.push_back('{17'hF001, 8'h17});
    send(8'h41, 8'h17);
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 100) begin
      if (mem_we) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL print_write: got %h=%h expected no write", mem_address, mem_wdata);
        else begin
          e = exp_q.pop_front();
          if (mem_address !== e.addr || mem_wdata !== e.data)
            $display("FAIL print_write: got %h=%h expected %h=%h", mem_address, mem_wdata, e.addr, e.data);
          else n_pass++;
        end
      end
      @(negedge clock);
      cyc++;
    end
    exp_q.delete();
    n_checks++; if (cyc !== 2) $display("FAIL print_cycles: got %0d expected 2", cyc); else n_pass++;
    n_checks++; if (cursor !== 11'd0) $display("FAIL print_cursor: got %0d expected 0", cursor); else n_pass++;
  endtask

  task automatic test_control();
    wr_t         e;
    int          cyc;
    logic [7:0]  codes [0:4];
    logic [10:0] curs  [0:4];
    logic [7:0]  txt   [0:1];
    codes = '{8'h0D, 8'h0A, 8'h08, 8'h0D, 8'h08};
    curs  = '{11'd2047, 11'd79, 11'd78, 11'd2047, 11'd2047};
    txt   = '{8'h41, 8'h42};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{17'hF000 + 17'(2 * i), txt[i]});
      exp_q.push_back('{17'hF001 + 17'(2 * i), 8'h1F});
      send(txt[i], 8'h1F);
      cyc = 0;
      while ((busy || exp_q.size() != 0) && cyc < 100) begin
        if (mem_we) begin
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL text_write: got %h=%h expected no write", mem_address, mem_wdata);
          else begin
            e = exp_q.pop_front();
            if (mem_address !== e.addr || mem_wdata !== e.data)
              $display("FAIL text_write: got %h=%h expected %h=%h", mem_address, mem_wdata, e.addr, e.data);
            else n_pass++;
          end
        end
        @(negedge clock);
        cyc++;
      end
      exp_q.delete();
      n_checks++; if (cyc !== 2) $display("FAIL text_cycles: got %0d expected 2", cyc); else n_pass++;
    end
    // Control codes: cursor moves, no memory access, ready again next cycle.
    for (int i = 0; i < 5; i++) begin
      send(codes[i], 8'h00);
      n_checks++; if (cursor !== curs[i]) $display("FAIL ctrl_cursor[%0d]: got %0d expected %0d", i, cursor, curs[i]); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL ctrl_ready[%0d]: got %b expected 1", i, in_ready); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL ctrl_mem_we[%0d]: got %b expected 0", i, mem_we); else n_pass++;
    end
  endtask

  task automatic test_scroll();
    wr_t         e;
    int          cyc;
    int          want;
    logic [7:0]  b, a;
    logic [16:0] src;
    apply_reset();
    for (int i = 0; i < 24; i++) send(8'h0A, 8'h00);
    n_checks++; if (cursor !== 11'd1919) $display("FAIL lf_cursor: got %0d expected 1919", cursor); else n_pass++;
    // Fill row 24; the 80th character lands in cell 1999 and scrolls.
    for (int i = 0; i < 80; i++) begin
      b = 8'h21 + 8'(i);
      a = 8'(i) ^ 8'h30;
      exp_q.push_back('{17'hFF00 + 17'(2 * i), b});
      exp_q.push_back('{17'hFF01 + 17'(2 * i), a});
      want = 2;
      if (i == 79) begin
        want = 7842;
        for (int k = 0; k < 3840; k++) begin
          src = 17'hF0A0 + 17'(k);
          if (src == 17'hFF9E)      exp_q.push_back('{17'hF000 + 17'(k), b});
          else if (src == 17'hFF9F) exp_q.push_back('{17'hF000 + 17'(k), a});
          else                      exp_q.push_back('{17'hF000 + 17'(k), rd(src)});
        end
        for (int j = 0; j < 160; j++)
          exp_q.push_back('{17'hFF00 + 17'(j), (j % 2 == 0) ? 8'h20 : a});
      end
      send(b, a);
      cyc = 0;
      while ((busy || exp_q.size() != 0) && cyc < 10000) begin
        if (mem_we) begin
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL scroll_write: got %h=%h expected no write", mem_address, mem_wdata);
          else begin
            e = exp_q.pop_front();
            if (mem_address !== e.addr || mem_wdata !== e.data)
              $display("FAIL scroll_write: got %h=%h expected %h=%h", mem_address, mem_wdata, e.addr, e.data);
            else n_pass++;
          end
        end
        @(negedge clock);
        cyc++;
      end
      exp_q.delete();
      n_checks++; if (cyc !== want) $display("FAIL scroll_cycles[%0d]: got %0d expected %0d", i, cyc, want); else n_pass++;
    end
    n_checks++; if (cursor !== 11'd1919) $display("FAIL scroll_cursor: got %0d expected 1919", cursor); else n_pass++;
  endtask

  task automatic test_form_feed();
    wr_t e;
    int  cyc;
    for (int j = 0; j < 4000; j++)
      exp_q.push_back('{17'hF000 + 17'(j), (j % 2 == 0) ? 8'h20 : 8'h07});
    send(8'h0C, 8'h07);
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 10000) begin
      if (mem_we) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL ff_write: got %h=%h expected no write", mem_address, mem_wdata);
        else begin
          e = exp_q.pop_front();
          if (mem_address !== e.addr || mem_wdata !== e.data)
            $display("FAIL ff_write: got %h=%h expected %h=%h", mem_address, mem_wdata, e.addr, e.data);
          else n_pass++;
        end
      end
      @(negedge clock);
      cyc++;
    end
    exp_q.delete();
    n_checks++; if (cyc !== 4000) $display("FAIL ff_cycles: got %0d expected 4000", cyc); else n_pass++;
    n_checks++; if (cursor !== 11'd2047) $display("FAIL ff_cursor: got %0d expected 2047", cursor); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ff_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int we_seen;
    for (int i = 0; i < 24; i++) send(8'h0A, 8'h00);
    send(8'h0A, 8'h4E);
    repeat (99) @(negedge clock);
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL abort_mem_we: got %b expected 0", mem_we); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL abort_ready_in_reset: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL abort_ready_after: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (cursor !== 11'd2047) $display("FAIL abort_cursor: got %0d expected 2047", cursor); else n_pass++;
    we_seen = 0;
    repeat (10) begin
      if (mem_we) we_seen++;
      @(negedge clock);
    end
    n_checks++; if (we_seen !== 0) $display("FAIL abort_quiet: got %0d writes expected 0", we_seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_print();
    test_control();
    test_scroll();
    test_form_feed();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
